atm_ledger_arbiter: RTL and testbench

//  Shares one account ledger (balance register file) between N_REQ ATM front-end FSMs.
//  - Round-robin arbitration among requesters.
//  - Serialises each transaction as one atomic read-check-write.
//  - Returns status plus the resulting source balance.

---
 rtl/atm_pkg.sv | 38 +++
 rtl/atm_rr_arbiter.sv | 39 +++
 rtl/atm_ledger_arbiter.sv | 268 ++++++++++++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM ledger arbiter: operation codes, result codes,
// transaction FSM states and a small op-classification helper.
package atm_pkg;

    localparam int OP_W     = 3;
    localparam int STATUS_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_DEP  = 3'd0,
        OP_WDR  = 3'd1,
        OP_BAL  = 3'd2,
        OP_XFER = 3'd3,
        OP_EXIT = 3'd4
    } op_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_OK       = 3'd0,
        ST_NSF      = 3'd1,
        ST_BAD_ACCT = 3'd2,
        ST_OVFL     = 3'd3,
        ST_LIMIT    = 3'd4,
        ST_BAD_OP   = 3'd5
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Operations that take money out of the source account.
    function automatic logic is_debit(input logic [OP_W-1:0] op_code);
        return (op_code == OP_WDR) || (op_code == OP_XFER);
    endfunction

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// rr_ptr (wrapping), returning a one-hot grant and its binary index.
module atm_rr_arbiter
    import atm_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_rot_full;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   rot_gnt;
    logic [2*N_REQ-1:0] gnt_dbl;
    logic [PTR_W-1:0]   idx_acc [N_REQ+1];

    // Rotate so rr_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign req_dbl      = {req, req};
    assign req_rot_full = req_dbl >> rr_ptr;
    assign req_rot      = req_rot_full[N_REQ-1:0];
    assign rot_gnt      = req_rot & ~(req_rot - N_REQ'(1));
    assign gnt_dbl      = {{N_REQ{1'b0}}, rot_gnt} << rr_ptr;
    assign gnt          = gnt_dbl[N_REQ-1:0] | gnt_dbl[2*N_REQ-1:N_REQ];
    assign any          = |req;

    // One-hot to binary by OR-accumulating each position's index.
    assign idx_acc[0] = '0;
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_enc
        assign idx_acc[gi+1] = idx_acc[gi] | ({PTR_W{gnt[gi]}} & PTR_W'(gi));
    end
    assign gnt_idx = idx_acc[N_REQ];

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared ATM ledger with round-robin access for N_REQ terminals. Each granted
// transaction runs IDLE -> READ -> CHECK -> WRITE -> RESP as one atomic
// read-check-write; this block is the only writer of account balances.
// Optional feature: define ATM_WDRAW_LIMIT_EN to add per-account cumulative
// withdraw/transfer-out counters and the LIMIT result.
module atm_ledger_arbiter
    import atm_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int NUM_ACCTS    = 4,
    parameter int IDX_W        = 2,
    parameter int BAL_W        = 12,
    parameter int AMT_W        = 6,
    parameter int INIT_BALANCE = 100,
    parameter int WDRAW_LIMIT  = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [3*N_REQ-1:0]     op,
    input  logic [IDX_W*N_REQ-1:0] src_idx,
    input  logic [IDX_W*N_REQ-1:0] dst_idx,
    input  logic [AMT_W*N_REQ-1:0] amount,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [2:0]             status,
    output logic [BAL_W-1:0]       balance,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int SUM_W = BAL_W + 1;

    // Per-terminal views of the flat request buses.
    logic [OP_W-1:0]  op_arr  [N_REQ];
    logic [IDX_W-1:0] src_arr [N_REQ];
    logic [IDX_W-1:0] dst_arr [N_REQ];
    logic [AMT_W-1:0] amt_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign op_arr[gi]  = op[gi*OP_W +: OP_W];
        assign src_arr[gi] = src_idx[gi*IDX_W +: IDX_W];
        assign dst_arr[gi] = dst_idx[gi*IDX_W +: IDX_W];
        assign amt_arr[gi] = amount[gi*AMT_W +: AMT_W];
    end

    state_e           state_reg, state_next;
    logic [PTR_W-1:0] rr_ptr_reg;
    logic [PTR_W-1:0] gidx_reg;
    logic [N_REQ-1:0] gnt_reg;
    logic [N_REQ-1:0] done_reg;
    logic [OP_W-1:0]  op_reg;
    logic [IDX_W-1:0] src_reg, dst_reg;
    logic [AMT_W-1:0] amt_reg;

    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_any;

    atm_rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // Fixed five-step sequence; only IDLE waits for a request.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (arb_any) state_next = S_READ;
            S_READ:  state_next = S_CHECK;
            S_CHECK: state_next = S_WRITE;
            S_WRITE: state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Grant and latch the winner's fields; the terminal may change them afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg    <= '0;
            gidx_reg   <= '0;
            rr_ptr_reg <= '0;
            op_reg     <= '0;
            src_reg    <= '0;
            dst_reg    <= '0;
            amt_reg    <= '0;
        end else if (state_reg == S_IDLE && arb_any) begin
            gnt_reg  <= arb_gnt;
            gidx_reg <= arb_idx;
            op_reg   <= op_arr[arb_idx];
            src_reg  <= src_arr[arb_idx];
            dst_reg  <= dst_arr[arb_idx];
            amt_reg  <= amt_arr[arb_idx];
        end else if (state_reg == S_RESP) begin
            gnt_reg    <= '0;
            rr_ptr_reg <= (int'(gidx_reg) == N_REQ - 1) ? '0 : gidx_reg + PTR_W'(1);
        end
    end

    logic src_ok, dst_ok;
    assign src_ok = int'(src_reg) < NUM_ACCTS;
    assign dst_ok = int'(dst_reg) < NUM_ACCTS;

    logic [BAL_W-1:0] ledger_q [NUM_ACCTS];
    logic [BAL_W-1:0] src_bal_reg, dst_bal_reg;

`ifdef ATM_WDRAW_LIMIT_EN
    logic [BAL_W-1:0] cnt_q [NUM_ACCTS];
    logic [BAL_W-1:0] cnt_src_reg;

    // Snapshot the source account's running withdrawal total.
    always_ff @(posedge clk) begin
        if (rst)                     cnt_src_reg <= '0;
        else if (state_reg == S_READ) cnt_src_reg <= src_ok ? cnt_q[src_reg] : '0;
    end
`endif

    // Snapshot both balances; out-of-range indices read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_bal_reg <= '0;
            dst_bal_reg <= '0;
        end else if (state_reg == S_READ) begin
            src_bal_reg <= src_ok ? ledger_q[src_reg] : '0;
            dst_bal_reg <= dst_ok ? ledger_q[dst_reg] : '0;
        end
    end

    logic             is_dep, is_xfer, is_debit_op;
    logic [SUM_W-1:0] amt_ext, src_ext, src_sum, dst_sum;
    status_e          chk_status;
    logic [BAL_W-1:0] new_src, new_dst, resp_bal;

    assign is_dep      = (op_reg == OP_DEP);
    assign is_xfer     = (op_reg == OP_XFER);
    assign is_debit_op = is_debit(op_reg);
    assign amt_ext     = SUM_W'(amt_reg);
    assign src_ext     = SUM_W'(src_bal_reg);
    assign src_sum     = src_ext + amt_ext;
    assign dst_sum     = SUM_W'(dst_bal_reg) + amt_ext;

`ifdef ATM_WDRAW_LIMIT_EN
    logic [SUM_W-1:0] cnt_sum;
    assign cnt_sum = SUM_W'(cnt_src_reg) + amt_ext;
`endif

    // Result code with first-match priority, plus the post-write values.
    always_comb begin
        chk_status = ST_OK;
        new_src    = src_bal_reg;
        new_dst    = dst_bal_reg;
        resp_bal   = '0;
        if (op_reg > OP_EXIT) begin
            chk_status = ST_BAD_OP;
        end else if (!src_ok || (is_xfer && (!dst_ok || dst_reg == src_reg))) begin
            chk_status = ST_BAD_ACCT;
        end else if (is_debit_op && (amt_ext > src_ext)) begin
            chk_status = ST_NSF;
`ifdef ATM_WDRAW_LIMIT_EN
        end else if (is_debit_op && (cnt_sum > SUM_W'(WDRAW_LIMIT))) begin
            chk_status = ST_LIMIT;
`endif
        end else if ((is_dep && src_sum[BAL_W]) || (is_xfer && dst_sum[BAL_W])) begin
            chk_status = ST_OVFL;
        end
        if (chk_status == ST_OK) begin
            if (is_dep)      new_src = src_sum[BAL_W-1:0];
            if (is_debit_op) new_src = src_bal_reg - BAL_W'(amt_reg);
            if (is_xfer)     new_dst = dst_sum[BAL_W-1:0];
        end
        if (chk_status == ST_BAD_ACCT || op_reg == OP_EXIT) resp_bal = '0;
        else                                                resp_bal = new_src;
    end

    status_e          chk_status_reg;
    logic [BAL_W-1:0] new_src_reg, new_dst_reg, resp_bal_reg;
    logic             wr_src_reg, wr_dst_reg, wr_cnt_reg;

    // Register the decision so WRITE only has to commit it.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_status_reg <= ST_OK;
            new_src_reg    <= '0;
            new_dst_reg    <= '0;
            resp_bal_reg   <= '0;
            wr_src_reg     <= 1'b0;
            wr_dst_reg     <= 1'b0;
            wr_cnt_reg     <= 1'b0;
        end else if (state_reg == S_CHECK) begin
            chk_status_reg <= chk_status;
            new_src_reg    <= new_src;
            new_dst_reg    <= new_dst;
            resp_bal_reg   <= resp_bal;
            wr_src_reg     <= (chk_status == ST_OK) && (is_dep || is_debit_op);
            wr_dst_reg     <= (chk_status == ST_OK) && is_xfer;
            wr_cnt_reg     <= (chk_status == ST_OK) && is_debit_op;
        end
    end

    // One balance register per account; XFER updates two of them in the same cycle.
    for (genvar gi = 0; gi < NUM_ACCTS; gi++) begin : g_acct
        logic [BAL_W-1:0] bal_reg;

        // Commit the new balance when this account is the write target.
        always_ff @(posedge clk) begin
            if (rst) begin
                bal_reg <= BAL_W'(INIT_BALANCE);
            end else if (state_reg == S_WRITE) begin
                if (wr_dst_reg && int'(dst_reg) == gi)      bal_reg <= new_dst_reg;
                else if (wr_src_reg && int'(src_reg) == gi) bal_reg <= new_src_reg;
            end
        end
        assign ledger_q[gi] = bal_reg;

`ifdef ATM_WDRAW_LIMIT_EN
        logic [BAL_W-1:0] cnt_reg;

        // Accumulate successful outflows from this account.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (state_reg == S_WRITE && wr_cnt_reg && int'(src_reg) == gi) begin
                cnt_reg <= cnt_reg + BAL_W'(amt_reg);
            end
        end
        assign cnt_q[gi] = cnt_reg;
`endif
    end

    status_e          status_reg;
    logic [BAL_W-1:0] balance_reg;

    // Response: done pulses during RESP, status and balance hold until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_reg    <= '0;
            status_reg  <= ST_OK;
            balance_reg <= '0;
        end else begin
            done_reg <= '0;
            if (state_reg == S_WRITE) begin
                done_reg    <= gnt_reg;
                status_reg  <= chk_status_reg;
                balance_reg <= resp_bal_reg;
            end
        end
    end

    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign status  = status_reg;
    assign balance = balance_reg;
    assign busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Self-checking bench for atm_ledger_arbiter: directed scenarios plus
// randomized traffic compared against a plain-arithmetic ledger model.
module tb_atm_ledger_arbiter;

    localparam int NACC    = 4;
    localparam int INIT    = 100;
    localparam int MAXBAL  = 4095;
    localparam int WLIMIT  = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [5:0]  op;
    logic [3:0]  src_idx, dst_idx;
    logic [11:0] amount;
    logic [1:0]  gnt, done;
    logic [2:0]  status;
    logic [11:0] balance;
    logic        busy;

    int errors = 0;
    int checks = 0;

    int m_bal [NACC];
    int m_cnt [NACC];
    int m_rr;

    atm_ledger_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .op      (op),
        .src_idx (src_idx),
        .dst_idx (dst_idx),
        .amount  (amount),
        .gnt     (gnt),
        .done    (done),
        .status  (status),
        .balance (balance),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) begin
            m_bal[i] = INIT;
            m_cnt[i] = 0;
        end
        m_rr = 0;
    endtask

    // Reference ledger: applies one transaction, returns expected status/balance.
    task automatic model_txn(input int t, input int o, input int s, input int d, input int a,
                             output int st, output int bal);
        bit debit;
        debit = (o == 1) || (o == 3);
        if (o > 4)                                        st = 5;
        else if (s >= NACC || (o == 3 && (d >= NACC || d == s))) st = 2;
        else if (debit && a > m_bal[s])                   st = 1;
`ifdef ATM_WDRAW_LIMIT_EN
        else if (debit && m_cnt[s] + a > WLIMIT)          st = 4;
`endif
        else if ((o == 0 && m_bal[s] + a > MAXBAL) || (o == 3 && m_bal[d] + a > MAXBAL)) st = 3;
        else                                              st = 0;
        if (st == 0) begin
            if (o == 0) m_bal[s] += a;
            if (debit) begin
                m_bal[s] -= a;
                m_cnt[s] += a;
            end
            if (o == 3) m_bal[d] += a;
        end
        bal  = (st == 2 || o == 4) ? 0 : m_bal[s];
        m_rr = (t + 1) % 2;
    endtask

    task automatic set_fields(input int t, input int o, input int s, input int d, input int a);
        op[t*3 +: 3]      = 3'(o);
        src_idx[t*2 +: 2] = 2'(s);
        dst_idx[t*2 +: 2] = 2'(d);
        amount[t*6 +: 6]  = 6'(a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One transaction from an idle DUT, checked against the model.
    task automatic run_txn(input int t, input int o, input int s, input int d, input int a,
                           output int st_o, output int bal_o);
        int cyc;
        bit got;
        int exp_st, exp_bal;
        @(negedge clk);
        set_fields(t, o, s, d, a);
        req[t] = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (gnt == 2'b11) begin
                checks++;
                errors++;
                $display("FAIL gnt_overlap t=%0d gnt=%b required one-hot", t, gnt);
            end
            if (done[t]) got = 1'b1;
        end
        req[t] = 1'b0;
        st_o  = -1;
        bal_o = -1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout t=%0d op=%0d no done within 20 cycles", t, o);
            return;
        end
        model_txn(t, o, s, d, a, exp_st, exp_bal);
        st_o  = int'(status);
        bal_o = int'(balance);
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL latency t=%0d got=%0d required=4", t, cyc);
        end
        checks++;
        if (status !== 3'(exp_st)) begin
            errors++;
            $display("FAIL status t=%0d op=%0d s=%0d d=%0d a=%0d got=%0d required=%0d",
                     t, o, s, d, a, status, exp_st);
        end
        checks++;
        if (balance !== 12'(exp_bal)) begin
            errors++;
            $display("FAIL balance t=%0d op=%0d s=%0d d=%0d a=%0d got=%0d required=%0d",
                     t, o, s, d, a, balance, exp_bal);
        end
        checks++;
        if (done !== 2'(1 << t) || gnt[t] !== 1'b1) begin
            errors++;
            $display("FAIL resp_handshake t=%0d done=%b gnt=%b required done one-hot with gnt", t, done, gnt);
        end
        $display("txn t=%0d op=%0d src=%0d dst=%0d amt=%0d -> status=%0d balance=%0d",
                 t, o, s, d, a, status, balance);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        op = '0; src_idx = '0; dst_idx = '0; amount = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || status !== 3'd0 || balance !== 12'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b done=%b status=%0d balance=%0d busy=%b required all zero",
                     gnt, done, status, balance, busy);
        end
    endtask

    task automatic test_balance_inquiry();
        int st, bal;
        run_txn(0, 2, 1, 0, 0, st, bal);
        checks++;
        if (st != 0 || bal != 100) begin
            errors++;
            $display("FAIL bal_acct1 status=%0d balance=%0d required 0/100", st, bal);
        end
    endtask

    task automatic test_dep_wdr();
        int st, bal;
        run_txn(0, 0, 0, 0, 30, st, bal);
        checks++;
        if (st != 0 || bal != 130) begin
            errors++;
            $display("FAIL dep30 status=%0d balance=%0d required 0/130", st, bal);
        end
        run_txn(0, 1, 0, 0, 60, st, bal);
        checks++;
        if (st != 0 || bal != 70) begin
            errors++;
            $display("FAIL wdr60 status=%0d balance=%0d required 0/70", st, bal);
        end
    endtask

    task automatic test_xfer();
        int st, bal;
        run_txn(1, 3, 2, 3, 50, st, bal);
        checks++;
        if (st != 0 || bal != 50) begin
            errors++;
            $display("FAIL xfer50 status=%0d balance=%0d required 0/50", st, bal);
        end
        run_txn(1, 2, 3, 0, 0, st, bal);
        checks++;
        if (bal != 150) begin
            errors++;
            $display("FAIL bal_acct3 balance=%0d required 150", bal);
        end
        run_txn(1, 3, 2, 3, 63, st, bal);
        checks++;
        if (st != 1 || bal != 50) begin
            errors++;
            $display("FAIL xfer63_nsf status=%0d balance=%0d required 1/50", st, bal);
        end
        run_txn(0, 2, 3, 0, 0, st, bal);
        checks++;
        if (bal != 150) begin
            errors++;
            $display("FAIL acct3_after_nsf balance=%0d required 150", bal);
        end
    endtask

    task automatic test_errors();
        int st, bal;
        run_txn(0, 3, 1, 1, 10, st, bal);
        checks++;
        if (st != 2 || bal != 0) begin
            errors++;
            $display("FAIL xfer_same_acct status=%0d balance=%0d required 2/0", st, bal);
        end
        run_txn(1, 7, 0, 0, 5, st, bal);
        checks++;
        if (st != 5) begin
            errors++;
            $display("FAIL bad_op status=%0d required 5", st);
        end
        run_txn(0, 0, 2, 0, 0, st, bal);
        checks++;
        if (st != 0 || bal != 50) begin
            errors++;
            $display("FAIL zero_amount status=%0d balance=%0d required 0/50", st, bal);
        end
        run_txn(1, 4, 2, 0, 9, st, bal);
        checks++;
        if (st != 0 || bal != 0) begin
            errors++;
            $display("FAIL exit status=%0d balance=%0d required 0/0", st, bal);
        end
    endtask

    task automatic test_rst_mid_txn();
        int st, bal;
        @(negedge clk);
        set_fields(0, 0, 0, 0, 30);
        req[0] = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy busy=%b required 1 before reset", busy);
        end
        rst = 1'b1;
        req = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_done cycle=%0d done=%b required 00", c, done);
            end
        end
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < NACC; a++) begin
            run_txn(a % 2, 2, a, 0, 0, st, bal);
            checks++;
            if (bal != 100) begin
                errors++;
                $display("FAIL rst_reinit acct=%0d balance=%0d required 100", a, bal);
            end
        end
    endtask

    // Both terminals request together; order must follow the rotating pointer.
    task automatic test_back_to_back();
        int o[2], s[2], d[2], a[2];
        int exp_st, exp_bal, first, exp_first, cyc;
        logic [1:0] served;
        do_reset();
        for (int p = 0; p < 10; p++) begin
            for (int t = 0; t < 2; t++) begin
                o[t] = $urandom_range(0, 4);
                s[t] = $urandom_range(0, 3);
                d[t] = $urandom_range(0, 3);
                a[t] = $urandom_range(0, 63);
            end
            @(negedge clk);
            set_fields(0, o[0], s[0], d[0], a[0]);
            set_fields(1, o[1], s[1], d[1], a[1]);
            req = 2'b11;
            exp_first = m_rr;
            served = 2'b00;
            first = -1;
            cyc = 0;
            while (served != 2'b11 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (gnt == 2'b11) begin
                    checks++;
                    errors++;
                    $display("FAIL pair_gnt_overlap pair=%0d gnt=%b required one-hot", p, gnt);
                end
                for (int t = 0; t < 2; t++) begin
                    if (done[t] && !served[t]) begin
                        model_txn(t, o[t], s[t], d[t], a[t], exp_st, exp_bal);
                        checks++;
                        if (status !== 3'(exp_st) || balance !== 12'(exp_bal)) begin
                            errors++;
                            $display("FAIL pair_result pair=%0d t=%0d got=%0d/%0d required=%0d/%0d",
                                     p, t, status, balance, exp_st, exp_bal);
                        end
                        $display("pair %0d t=%0d op=%0d src=%0d dst=%0d amt=%0d -> status=%0d balance=%0d",
                                 p, t, o[t], s[t], d[t], a[t], status, balance);
                        served[t] = 1'b1;
                        req[t] = 1'b0;
                        if (first < 0) first = t;
                    end
                end
            end
            req = '0;
            checks++;
            if (served != 2'b11) begin
                errors++;
                $display("FAIL pair_timeout pair=%0d served=%b required 11", p, served);
            end
            checks++;
            if (first != exp_first) begin
                errors++;
                $display("FAIL pair_order pair=%0d first=%0d required=%0d", p, first, exp_first);
            end
        end
    endtask

    // Deposit until the source would exceed the balance width.
    task automatic test_overflow();
        int st, bal;
        bit seen;
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 70 && !seen; i++) begin
            run_txn(i % 2, 0, 3, 0, 63, st, bal);
            if (st == 3) seen = 1'b1;
        end
        checks++;
        if (!seen || bal != 4069) begin
            errors++;
            $display("FAIL ovfl_boundary seen=%0d balance=%0d required 1/4069", seen, bal);
        end
    endtask

    task automatic test_random();
        int st, bal;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 63), st, bal);
        end
    endtask

`ifdef ATM_WDRAW_LIMIT_EN
    task automatic test_limit();
        int st, bal;
        do_reset();
        run_txn(0, 1, 0, 0, 30, st, bal);
        checks++;
        if (st != 0 || bal != 70) begin
            errors++;
            $display("FAIL limit_wdr30 status=%0d balance=%0d required 0/70", st, bal);
        end
        run_txn(0, 1, 0, 0, 20, st, bal);
        checks++;
        if (st != 4 || bal != 70) begin
            errors++;
            $display("FAIL limit_wdr20 status=%0d balance=%0d required 4/70", st, bal);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_balance_inquiry();
        test_dep_wdr();
        test_xfer();
        test_errors();
        test_rst_mid_txn();
        test_back_to_back();
        test_overflow();
        test_random();
`ifdef ATM_WDRAW_LIMIT_EN
        test_limit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
